// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI read arbiter: instruction fetch (s0) and data (s1) share one
// memory read port, one burst at a time, round-robin on contention.
module axi_rd_arbiter #(
  parameter int ADDR_W = 40,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) (
  input  logic              clock,
  input  logic              reset,
  // requester 0 (instruction fetch)
  input  logic              s0_arvalid,
  output logic              s0_arready,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [7:0]        s0_arlen,
  input  logic [2:0]        s0_arsize,
  input  logic [1:0]        s0_arburst,
  input  logic [ID_W-1:0]   s0_arid,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  output logic [DATA_W-1:0] s0_rdata,
  output logic [1:0]        s0_rresp,
  output logic              s0_rlast,
  output logic [ID_W-1:0]   s0_rid,
  // requester 1 (data)
  input  logic              s1_arvalid,
  output logic              s1_arready,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [7:0]        s1_arlen,
  input  logic [2:0]        s1_arsize,
  input  logic [1:0]        s1_arburst,
  input  logic [ID_W-1:0]   s1_arid,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  output logic [DATA_W-1:0] s1_rdata,
  output logic [1:0]        s1_rresp,
  output logic              s1_rlast,
  output logic [ID_W-1:0]   s1_rid,
  // shared memory port
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic [ID_W-1:0]   m_arid,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic [ID_W-1:0]   m_rid,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_q, grant_d;
  logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
  logic [7:0]        ar_len_q, ar_len_d;
  logic [2:0]        ar_size_q, ar_size_d;
  logic [1:0]        ar_burst_q, ar_burst_d;
  logic [ID_W-1:0]   ar_id_q, ar_id_d;
  logic              busy_q, busy_d;
  logic              m_arvalid_q, m_arvalid_d;

  logic pick;
  logic grant_take;
  logic sel_rready;

  // Round-robin pick: on contention favour the requester not served last; a lone requester always wins.
  always_comb begin
    if (s0_arvalid && s1_arvalid) begin
      pick = ~last_grant_q;
    end else begin
      pick = s1_arvalid;
    end
    grant_take = (state_q == IDLE) && (s0_arvalid || s1_arvalid) && !reset;
    s0_arready = grant_take && !pick;
    s1_arready = grant_take && pick;
  end

  // Next-state logic: latch the winner's AR payload, issue it, then stream R beats until rlast.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    ar_addr_d    = ar_addr_q;
    ar_len_d     = ar_len_q;
    ar_size_d    = ar_size_q;
    ar_burst_d   = ar_burst_q;
    ar_id_d      = ar_id_q;
    case (state_q)
      IDLE: begin
        if (grant_take) begin
          grant_d    = pick;
          ar_addr_d  = pick ? s1_araddr  : s0_araddr;
          ar_len_d   = pick ? s1_arlen   : s0_arlen;
          ar_size_d  = pick ? s1_arsize  : s0_arsize;
          ar_burst_d = pick ? s1_arburst : s0_arburst;
          ar_id_d    = pick ? s1_arid    : s0_arid;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        if (m_arready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (m_rvalid && m_rready && m_rlast) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d      = (state_d != IDLE);
    m_arvalid_d = (state_d == ADDR);
  end

  // State, grant history, latched AR payload and registered status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      ar_addr_q    <= '0;
      ar_len_q     <= '0;
      ar_size_q    <= '0;
      ar_burst_q   <= '0;
      ar_id_q      <= '0;
      busy_q       <= 1'b0;
      m_arvalid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      ar_addr_q    <= ar_addr_d;
      ar_len_q     <= ar_len_d;
      ar_size_q    <= ar_size_d;
      ar_burst_q   <= ar_burst_d;
      ar_id_q      <= ar_id_d;
      busy_q       <= busy_d;
      m_arvalid_q  <= m_arvalid_d;
    end
  end

  // R channel steering: only the granted requester sees rvalid and drives m_rready, and only in DATA.
  always_comb begin
    sel_rready = grant_q ? s1_rready : s0_rready;
    m_rready   = (state_q == DATA) && sel_rready;
    s0_rvalid  = (state_q == DATA) && !grant_q && m_rvalid;
    s1_rvalid  = (state_q == DATA) && grant_q && m_rvalid;
    s0_rdata   = m_rdata;
    s0_rresp   = m_rresp;
    s0_rlast   = m_rlast;
    s0_rid     = m_rid;
    s1_rdata   = m_rdata;
    s1_rresp   = m_rresp;
    s1_rlast   = m_rlast;
    s1_rid     = m_rid;
  end

  assign busy      = busy_q;
  assign m_arvalid = m_arvalid_q;
  assign m_araddr  = ar_addr_q;
  assign m_arlen   = ar_len_q;
  assign m_arsize  = ar_size_q;
  assign m_arburst = ar_burst_q;
  assign m_arid    = ar_id_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: a memory responder model feeds R beats and a scoreboard
// checks each beat arrives at the requester the round-robin model says it should.
module tb_axi_rd_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready, s0_rlast;
  logic [39:0] s0_araddr;
  logic [7:0]  s0_arlen;
  logic [2:0]  s0_arsize;
  logic [1:0]  s0_arburst, s0_rresp;
  logic [3:0]  s0_arid, s0_rid;
  logic [63:0] s0_rdata;
  logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready, s1_rlast;
  logic [39:0] s1_araddr;
  logic [7:0]  s1_arlen;
  logic [2:0]  s1_arsize;
  logic [1:0]  s1_arburst, s1_rresp;
  logic [3:0]  s1_arid, s1_rid;
  logic [63:0] s1_rdata;
  logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [39:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst, m_rresp;
  logic [3:0]  m_arid, m_rid;
  logic [63:0] m_rdata;
  logic        busy;

  axi_rd_arbiter dut (
    .clock(clock), .reset(reset),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr),
    .s0_arlen(s0_arlen), .s0_arsize(s0_arsize), .s0_arburst(s0_arburst), .s0_arid(s0_arid),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
    .s0_rlast(s0_rlast), .s0_rid(s0_rid),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr),
    .s1_arlen(s1_arlen), .s1_arsize(s1_arsize), .s1_arburst(s1_arburst), .s1_arid(s1_arid),
    .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
    .s1_rlast(s1_rlast), .s1_rid(s1_rid),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arid(m_arid),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rid(m_rid),
    .busy(busy)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  typedef struct {
    logic        req;
    logic [39:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  id;
    logic [1:0]  last_resp;
    int          ar_delay;
    logic        toggle;
  } vec_t;

  typedef struct {
    logic        req;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } beat_t;

  vec_t  exp_bursts[$];
  beat_t exp_beats[$];
  int    checks = 0;
  int    failures = 0;
  int    delivered = 0;
  vec_t  cur;
  int    beat;
  int    phase;

  function automatic logic [63:0] beat_data(input logic [39:0] a, input int b);
    return {a[31:0] ^ 32'hDEAD_0000, 32'(b) + 32'h0000_0100};
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic present_beat();
    logic last;
    beat_t e;
    last = (beat == int'(cur.len));
    m_rvalid = 1'b1;
    m_rdata  = beat_data(cur.addr, beat);
    m_rresp  = last ? cur.last_resp : 2'b00;
    m_rlast  = last;
    m_rid    = cur.id;
    e.req  = cur.req;
    e.data = m_rdata;
    e.resp = m_rresp;
    e.last = last;
    e.id   = cur.id;
    exp_beats.push_back(e);
  endtask

  task automatic consume(input logic n, input logic [63:0] d, input logic [1:0] r,
                         input logic l, input logic [3:0] id);
    beat_t e;
    if (exp_beats.size() == 0) begin
      check_output("beat_unexpected", 1, 0);
    end else begin
      e = exp_beats.pop_front();
      check_output("beat_req", n, e.req);
      check_output("beat_data", d, e.data);
      check_output("beat_resp", r, e.resp);
      check_output("beat_last", l, e.last);
      check_output("beat_id", id, e.id);
      delivered++;
    end
  endtask

  // Memory-side responder: accepts AR after a programmable stall, streams beats, checks routing.
  initial begin : responder
    logic ar_hs, r_hs;
    int   stall;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rid = '0;
    phase = 0; beat = 0; stall = 0;
    forever begin
      @(negedge clock);
      ar_hs = m_arvalid && m_arready;
      r_hs  = m_rvalid && m_rready;
      if (!reset && phase == 1 && m_arvalid) begin
        check_output("ar_addr_stable", m_araddr, cur.addr);
        check_output("ar_len_stable", m_arlen, cur.len);
        check_output("ar_id_stable", m_arid, cur.id);
        check_output("arready_in_addr", {s0_arready, s1_arready}, 2'b00);
      end
      if (!reset && phase == 2 && m_rvalid) begin
        check_output("route_rvalid", {s1_rvalid, s0_rvalid}, cur.req ? 2'b10 : 2'b01);
        check_output("route_rready", m_rready, cur.req ? s1_rready : s0_rready);
      end
      if (s0_rvalid && s0_rready) consume(1'b0, s0_rdata, s0_rresp, s0_rlast, s0_rid);
      if (s1_rvalid && s1_rready) consume(1'b1, s1_rdata, s1_rresp, s1_rlast, s1_rid);
      @(posedge clock);
      #1;
      if (reset) begin
        phase = 0; m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
        continue;
      end
      case (phase)
        0: if (m_arvalid) begin
          if (exp_bursts.size() == 0) begin
            check_output("ar_unexpected", 1, 0);
            cur = '{req: 1'b0, addr: m_araddr, len: m_arlen, size: m_arsize, burst: m_arburst,
                    id: m_arid, last_resp: 2'b00, ar_delay: 0, toggle: 1'b0};
          end else begin
            cur = exp_bursts.pop_front();
            check_output("ar_addr", m_araddr, cur.addr);
            check_output("ar_len", m_arlen, cur.len);
            check_output("ar_size", m_arsize, cur.size);
            check_output("ar_burst", m_arburst, cur.burst);
            check_output("ar_id", m_arid, cur.id);
          end
          stall = cur.ar_delay;
          m_arready = (stall == 0);
          phase = 1;
        end
        1: if (ar_hs) begin
          m_arready = 1'b0;
          phase = 2;
          beat = 0;
          present_beat();
        end else begin
          if (stall > 0) stall--;
          m_arready = (stall == 0);
        end
        2: if (r_hs) begin
          if (m_rlast) begin
            m_rvalid = 1'b0; m_rlast = 1'b0; phase = 0;
          end else begin
            beat++;
            present_beat();
          end
        end
        default: phase = 0;
      endcase
    end
  end

  task automatic drive_req(input vec_t v);
    if (v.req) begin
      s1_arvalid = 1'b1; s1_araddr = v.addr; s1_arlen = v.len; s1_arsize = v.size;
      s1_arburst = v.burst; s1_arid = v.id;
    end else begin
      s0_arvalid = 1'b1; s0_araddr = v.addr; s0_arlen = v.len; s0_arsize = v.size;
      s0_arburst = v.burst; s0_arid = v.id;
    end
  endtask

  // Drop the request and scramble the payload so any use of unlatched inputs shows up.
  task automatic clear_req(input logic req);
    if (req) begin
      s1_arvalid = 1'b0; s1_araddr = '1; s1_arlen = '1; s1_arid = '1;
    end else begin
      s0_arvalid = 1'b0; s0_araddr = '1; s0_arlen = '1; s0_arid = '1;
    end
  endtask

  task automatic wait_idle(input logic req, input logic toggle);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clock);
      if (!busy) begin
        done = 1'b1;
      end else begin
        check_output("arready_while_busy", {s0_arready, s1_arready}, 2'b00);
        @(posedge clock);
        #1;
        if (toggle) begin
          if (req) s1_rready = ~s1_rready;
          else s0_rready = ~s0_rready;
        end
      end
    end
    if (!done) check_output("idle_timeout", 1, 0);
  endtask

  task automatic apply_stimulus(input vec_t v);
    delivered = 0;
    @(posedge clock);
    #1;
    drive_req(v);
    exp_bursts.push_back(v);
    @(negedge clock);
    check_output("grant_s0", s0_arready, v.req == 1'b0);
    check_output("grant_s1", s1_arready, v.req == 1'b1);
    @(posedge clock);
    #1;
    clear_req(v.req);
    wait_idle(v.req, v.toggle);
    check_output("beats_delivered", delivered, int'(v.len) + 1);
    check_output("queues_empty", exp_beats.size() + exp_bursts.size(), 0);
    s0_rready = 1'b1;
    s1_rready = 1'b1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset state, table of single bursts, contention, reset mid-burst.
  initial begin
    vec_t vecs[6];
    vec_t a, b, c, r;
    logic hit;
    vecs[0] = '{1'b0, 40'h00_8000_0000, 8'd3, 3'd3, 2'd1, 4'h2, 2'b00, 0, 1'b0};
    vecs[1] = '{1'b1, 40'h00_1000_0040, 8'd7, 3'd3, 2'd1, 4'h5, 2'b00, 1, 1'b1};
    vecs[2] = '{1'b0, 40'h00_0000_0100, 8'd0, 3'd2, 2'd0, 4'h7, 2'b00, 5, 1'b0};
    vecs[3] = '{1'b1, 40'hFF_FFFF_FFF8, 8'd2, 3'd3, 2'd1, 4'hA, 2'b10, 0, 1'b0};
    vecs[4] = '{1'b0, 40'h12_3456_7890, 8'd1, 3'd3, 2'd2, 4'h1, 2'b11, 2, 1'b0};
    vecs[5] = '{1'b1, 40'h00_0000_0008, 8'd0, 3'd3, 2'd1, 4'hF, 2'b00, 0, 1'b1};

    s0_arvalid = 1'b1; s0_araddr = 40'h1; s0_arlen = '0; s0_arsize = '0; s0_arburst = '0; s0_arid = '0;
    s1_arvalid = 1'b0; s1_araddr = '0; s1_arlen = '0; s1_arsize = '0; s1_arburst = '0; s1_arid = '0;
    s0_rready = 1'b1; s1_rready = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_output("reset_arready", {s0_arready, s1_arready}, 2'b00);
    check_output("reset_busy", busy, 1'b0);
    check_output("reset_m_arvalid", m_arvalid, 1'b0);
    check_output("reset_m_rready", m_rready, 1'b0);
    check_output("reset_rvalid", {s0_rvalid, s1_rvalid}, 2'b00);
    @(posedge clock);
    #1;
    reset = 1'b0;
    s0_arvalid = 1'b0;

    for (int i = 0; i < 6; i++) apply_stimulus(vecs[i]);

    a = '{1'b0, 40'h00_0000_2000, 8'd1, 3'd3, 2'd1, 4'h1, 2'b00, 0, 1'b0};
    b = '{1'b1, 40'h00_0000_3000, 8'd2, 3'd3, 2'd1, 4'h9, 2'b00, 1, 1'b0};
    c = '{1'b0, 40'h00_0000_4000, 8'd0, 3'd3, 2'd1, 4'h3, 2'b00, 0, 1'b0};
    // Contention straight after a reset: s0 first, then s1, then s0 again.
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    drive_req(a);
    drive_req(b);
    exp_bursts.push_back(a);
    exp_bursts.push_back(b);
    exp_bursts.push_back(c);
    @(negedge clock);
    check_output("cont1_grant", {s0_arready, s1_arready}, 2'b10);
    @(posedge clock);
    #1;
    drive_req(c);
    wait_idle(1'b0, 1'b0);
    check_output("cont2_grant", {s0_arready, s1_arready}, 2'b01);
    @(posedge clock);
    #1;
    clear_req(1'b1);
    wait_idle(1'b1, 1'b0);
    check_output("cont3_grant", {s0_arready, s1_arready}, 2'b10);
    @(posedge clock);
    #1;
    clear_req(1'b0);
    wait_idle(1'b0, 1'b0);
    check_output("cont_queues_empty", exp_beats.size() + exp_bursts.size(), 0);

    // Reset while beat 2 of a 4-beat burst is on the bus.
    r = '{1'b0, 40'h00_0000_5000, 8'd3, 3'd3, 2'd1, 4'h6, 2'b00, 0, 1'b0};
    delivered = 0;
    @(posedge clock);
    #1;
    drive_req(r);
    exp_bursts.push_back(r);
    @(negedge clock);
    check_output("rst_seq_grant", s0_arready, 1'b1);
    @(posedge clock);
    #1;
    clear_req(1'b0);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clock);
      #2;
      if (delivered == 1) hit = 1'b1;
    end
    if (!hit) check_output("rst_seq_timeout", 1, 0);
    reset = 1'b1;
    drive_req(vecs[5]);
    @(negedge clock);
    check_output("midrst_busy", busy, 1'b0);
    check_output("midrst_m_rready", m_rready, 1'b0);
    check_output("midrst_rvalid", {s0_rvalid, s1_rvalid}, 2'b00);
    check_output("midrst_arready", {s0_arready, s1_arready}, 2'b00);
    check_output("midrst_m_arvalid", m_arvalid, 1'b0);
    exp_beats.delete();
    exp_bursts.delete();
    repeat (2) @(posedge clock);
    #1;
    clear_req(1'b1);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check_output("no_resume_busy", busy, 1'b0);
    check_output("no_resume_m_arvalid", m_arvalid, 1'b0);
    apply_stimulus(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
